// File: rtl/fake_mario_position_poller.sv
// Periodic Avalon-MM poller: reads a packed {y, x} position word from a PIO slave
// and publishes it with valid/changed strobes and a sticky timeout flag.
module fake_mario_position_poller #(
  parameter int POLL_PERIOD = 833333,
  parameter int TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [15:0] pos_x,
  output logic [15:0] pos_y,
  output logic        pos_valid,
  output logic        pos_changed,
  output logic        timeout_err
);

  localparam logic [19:0] PERIOD_LAST  = 20'(POLL_PERIOD - 1);
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [19:0] period_cnt_r;
  logic [7:0]  tmo_cnt_r;
  logic        first_r;
  logic        tick_s;
  logic        accept_s;
  logic        capture_s;
  logic        expire_s;
  logic        changed_s;

  function automatic logic sample_differs(input logic [31:0] cur, input logic [31:0] prev);
    return (cur != prev);
  endfunction

  assign tick_s    = enable && (period_cnt_r == PERIOD_LAST);
  // The published position doubles as the previous-sample register; a timeout never touches it.
  assign changed_s = first_r || sample_differs(avm_readdata, {pos_y, pos_x});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt_r <= 20'd0;
    end else if (!enable || tick_s) begin
      period_cnt_r <= 20'd0;
    end else begin
      period_cnt_r <= period_cnt_r + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Ticks arriving outside IDLE fall through unused, so they are dropped rather than queued.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    expire_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!avm_waitrequest) begin
          accept_s     = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (avm_readdatavalid) begin
          capture_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else if (tmo_cnt_r == TIMEOUT_LAST) begin
          expire_s     = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_r <= 8'd0;
    end else if (accept_s || (state_r != ST_RESP)) begin
      tmo_cnt_r <= 8'd0;
    end else if (!avm_readdatavalid) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end
  end

  // avm_read is registered from the next state so it is high exactly while in REQ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_address <= 2'd0;
      avm_read    <= 1'b0;
      pos_x       <= 16'd0;
      pos_y       <= 16'd0;
      pos_valid   <= 1'b0;
      pos_changed <= 1'b0;
      timeout_err <= 1'b0;
      first_r     <= 1'b1;
    end else begin
      avm_address <= 2'd0;
      avm_read    <= (state_next_s == ST_REQ);
      pos_valid   <= capture_s;
      pos_changed <= capture_s && changed_s;
      if (capture_s) begin
        pos_x       <= avm_readdata[15:0];
        pos_y       <= avm_readdata[31:16];
        first_r     <= 1'b0;
        timeout_err <= 1'b0;
      end else if (expire_s) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
